// File: rtl/i2c_target_if.sv
// Bus pins and local-logic handshake of the I2C target byte engine.
// The target drives the slave modport; the controller/local side owns master.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_out_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addressed;
    logic       rw;
    logic       start_det;
    logic       stop_det;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_out_low, rx_data, rx_valid, tx_req, addressed, rw, start_det, stop_det
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_out_low, rx_data, rx_valid, tx_req, addressed, rw, start_det, stop_det
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target byte engine: oversamples SCL/SDA, matches a 7-bit address, and
// moves bytes between the bus and local logic with ACK handling.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h3C
) (
    input logic         clk,
    input logic         rst,
    i2c_target_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       phase;
    logic       drive_low, rx_pulse, tx_pulse, addr_hit, rw_bit, start_pulse, stop_pulse;
    logic [7:0] rx_byte;
    logic       sclr, sclf, start_cond, stop_cond;
    logic [7:0] shifted;

    // NOTE: the synchronizer resets to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_in};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign sclr       = scl_sync[1] & ~scl_prev;
    assign sclf       = ~scl_sync[1] & scl_prev;
    assign start_cond = scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
    assign stop_cond  = scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
    assign shifted    = {shift[6:0], sda_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            phase       <= 1'b0;
            drive_low   <= 1'b0;
            rx_byte     <= '0;
            rx_pulse    <= 1'b0;
            tx_pulse    <= 1'b0;
            addr_hit    <= 1'b0;
            rw_bit      <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
        end else begin
            rx_pulse    <= 1'b0;
            tx_pulse    <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;

            // Local logic answers tx_req combinationally; capture its byte one cycle later.
            if (tx_pulse) shift <= bus.tx_data;

            if (start_cond) begin
                start_pulse <= 1'b1;
                addr_hit    <= 1'b0;
                drive_low   <= 1'b0;
                bit_cnt     <= '0;
                phase       <= 1'b0;
                state       <= S_ADDR;
            end else if (stop_cond) begin
                stop_pulse <= 1'b1;
                addr_hit   <= 1'b0;
                drive_low  <= 1'b0;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_ADDR: if (sclr) begin
                        shift   <= shifted;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shifted[7:1] == ADDR) begin
                                rw_bit <= shifted[0];
                                phase  <= 1'b0;
                                state  <= S_ADDR_ACK;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: if (sclf) begin
                        if (!phase) begin
                            drive_low <= 1'b1;
                            addr_hit  <= 1'b1;
                            tx_pulse  <= rw_bit;
                            phase     <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            bit_cnt <= '0;
                            if (rw_bit) begin
                                drive_low <= ~shift[7];
                                state     <= S_TX;
                            end else begin
                                drive_low <= 1'b0;
                                state     <= S_RX;
                            end
                        end
                    end
                    S_RX: if (sclr) begin
                        shift   <= shifted;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_byte  <= shifted;
                            rx_pulse <= 1'b1;
                            phase    <= 1'b0;
                            state    <= S_RX_ACK;
                        end
                    end
                    S_RX_ACK: if (sclf) begin
                        if (!phase) begin
                            drive_low <= 1'b1;
                            phase     <= 1'b1;
                        end else begin
                            drive_low <= 1'b0;
                            phase     <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= S_RX;
                        end
                    end
                    S_TX: if (sclf) begin
                        if (bit_cnt == 3'd7) begin
                            drive_low <= 1'b0;
                            bit_cnt   <= '0;
                            phase     <= 1'b0;
                            state     <= S_TX_ACK;
                        end else begin
                            shift     <= {shift[6:0], 1'b0};
                            drive_low <= ~shift[6];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                    S_TX_ACK: begin
                        // phase marks an ACK already seen; the next byte goes out on the following fall.
                        if (!phase && sclr) begin
                            if (!sda_sync[1]) begin
                                tx_pulse <= 1'b1;
                                phase    <= 1'b1;
                            end else begin
                                addr_hit <= 1'b0;
                                state    <= S_IGNORE;
                            end
                        end else if (phase && sclf) begin
                            drive_low <= ~shift[7];
                            phase     <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= S_TX;
                        end
                    end
                    S_IDLE, S_IGNORE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sda_out_low = drive_low;
    assign bus.rx_data     = rx_byte;
    assign bus.rx_valid    = rx_pulse;
    assign bus.tx_req      = tx_pulse;
    assign bus.addressed   = addr_hit;
    assign bus.rw          = rw_bit;
    assign bus.start_det   = start_pulse;
    assign bus.stop_det    = stop_pulse;

endmodule
